// File: rtl/alu_seq_pkg.sv
// Shared opcode encoding and ALU evaluation for alu_seq_pipe.
// alu_eval works on MAX_W-bit containers; only the low w bits are meaningful
// and the result is masked back to w bits.
package alu_seq_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned MAX_W = 32;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_NOR = 4'd5;
  localparam logic [OP_W-1:0] OP_SLT = 4'd6;
  localparam logic [OP_W-1:0] OP_SLL = 4'd7;
  localparam logic [OP_W-1:0] OP_SRL = 4'd8;
  localparam logic [OP_W-1:0] OP_SRA = 4'd9;

  typedef struct packed {
    logic [MAX_W-1:0] res;
    logic             c;
    logic             of;
  } alu_res_t;

  // Evaluate one opcode on w-bit operands held zero-extended in MAX_W bits.
  function automatic alu_res_t alu_eval(input logic [OP_W-1:0]  op,
                                        input logic [MAX_W-1:0] a,
                                        input logic [MAX_W-1:0] b,
                                        input int unsigned      w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W:0]   sum;
    logic             sa;
    logic             sb;
    logic             sr;
    int unsigned      shw;
    int unsigned      sh;
    alu_res_t         r;
    r    = '0;
    sum  = '0;
    sr   = 1'b0;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    sa   = a[5'(w - 1)];
    sb   = b[5'(w - 1)];
    // shift-amount field width = clog2(w), found with a fixed-bound loop
    shw  = 0;
    for (int i = 0; i < 6; i++) begin
      if ((32'd1 << i) < w) shw = i + 1;
    end
    sh = 32'(b[5:0]) & ((32'd1 << shw) - 32'd1);
    case (op)
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        sr    = sum[5'(w - 1)];
        r.c   = sum[6'(w)];
        r.of  = (sa == sb) && (sr != sa);
        r.res = sum[MAX_W-1:0];
      end
      OP_SUB: begin
        // bit w of the wrapped difference is the borrow
        sum   = {1'b0, a} - {1'b0, b};
        sr    = sum[5'(w - 1)];
        r.c   = sum[6'(w)];
        r.of  = (sa != sb) && (sr != sa);
        r.res = sum[MAX_W-1:0];
      end
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      OP_NOR: r.res = ~(a | b);
      // differing signs: A is smaller exactly when it is negative
      OP_SLT: r.res = MAX_W'((sa != sb) ? sa : (a < b));
      OP_SLL: r.res = a << sh;
      OP_SRL: r.res = a >> sh;
      // fill the vacated top bits of the w-bit field with the sign
      OP_SRA: r.res = (a >> sh) | (sa ? ~(mask >> sh) : '0);
      default: r = '0;
    endcase
    r.res = r.res & mask;
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key debouncer: 2-flop synchroniser, stability counter, accepted level and a
// one-cycle press pulse on the accepted released->pressed transition.
// Ports: clk, rst_n (async, active-high), key_raw in;
//        key_level (1 = pressed), key_press out.
module key_debounce #(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd500000,
  parameter logic        KEY_ACTIVE   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press
);

  localparam int unsigned       CNT_W    = 20;
  localparam logic [CNT_W-1:0] CNT_LAST = DEBOUNCE_CYC - CNT_W'(1);

  logic             sync0;
  logic             sync1;
  logic             sync_pressed_c;
  logic [CNT_W-1:0] cnt;

  assign sync_pressed_c = (sync1 == KEY_ACTIVE);

  // Synchroniser resets to the released level
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync0 <= ~KEY_ACTIVE;
      sync1 <= ~KEY_ACTIVE;
    end else begin
      sync0 <= key_raw;
      sync1 <= sync0;
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts it
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt       <= '0;
      key_level <= 1'b0;
      key_press <= 1'b0;
    end else begin
      key_press <= 1'b0;
      if (sync_pressed_c == key_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt       <= '0;
        key_level <= sync_pressed_c;
        key_press <= sync_pressed_c;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq_pipe.sv
// Key-stepped ALU with a two-stage valid/ready operand pipeline.
// Ports: clk, rst_n (async, active-high); key_next/key_prev raw keys;
//        in_valid/in_ready/dina/dinb operand side; out_valid/out_ready/doutr/
//        doutz/flag_c/flag_of/op_out result side; of_sticky/clr_of sticky
//        overflow; op_sel current opcode.
module alu_seq_pipe
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_OPS      = 10,
  parameter logic [19:0] DEBOUNCE_CYC = 20'd500000,
  parameter logic        KEY_ACTIVE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_next,
  input  logic                  key_prev,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] doutr,
  output logic                  doutz,
  output logic                  flag_c,
  output logic                  flag_of,
  output logic                  of_sticky,
  input  logic                  clr_of,
  output logic [OP_W-1:0]       op_sel,
  output logic [OP_W-1:0]       op_out
);

  localparam logic [OP_W-1:0] OP_LAST = OP_W'(NUM_OPS - 1);

  logic                  next_press;
  logic                  prev_press;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_a;
  logic [DATA_WIDTH-1:0] s1_b;
  logic [OP_W-1:0]       s1_op;
  logic                  s2_can_load_c;
  alu_res_t              alu_c;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .KEY_ACTIVE(KEY_ACTIVE)) u_deb_next (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw   (key_next),
    .key_level (),
    .key_press (next_press)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .KEY_ACTIVE(KEY_ACTIVE)) u_deb_prev (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw   (key_prev),
    .key_level (),
    .key_press (prev_press)
  );

  // Opcode register, wrapping both ways; simultaneous presses cancel
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      op_sel <= '0;
    end else if (next_press && !prev_press) begin
      op_sel <= (op_sel == OP_LAST) ? '0 : op_sel + OP_W'(1);
    end else if (prev_press && !next_press) begin
      op_sel <= (op_sel == '0) ? OP_LAST : op_sel - OP_W'(1);
    end
  end

  // No skid buffer: in_ready follows out_ready combinationally
  assign s2_can_load_c = !out_valid || out_ready;
  assign in_ready      = !s1_valid || s2_can_load_c;

  // Opcodes beyond the table decode to an all-zero result
  always_comb begin
    alu_c = '0;
    if (32'(s1_op) < NUM_OPS) begin
      alu_c = alu_eval(s1_op, MAX_W'(s1_a), MAX_W'(s1_b), DATA_WIDTH);
    end
  end

  // Stage 1: operands plus opcode snapshot
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= dina;
        s1_b  <= dinb;
        s1_op <= op_sel;
      end
    end
  end

  // Stage 2: registered result; holds while stalled
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      out_valid <= 1'b0;
      doutr     <= '0;
      doutz     <= 1'b0;
      flag_c    <= 1'b0;
      flag_of   <= 1'b0;
      op_out    <= '0;
    end else if (s2_can_load_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        doutr   <= alu_c.res[DATA_WIDTH-1:0];
        doutz   <= (alu_c.res == '0);
        flag_c  <= alu_c.c;
        flag_of <= alu_c.of;
        op_out  <= s1_op;
      end
    end
  end

  // Sticky overflow; a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      of_sticky <= 1'b0;
    end else if (out_valid && out_ready && flag_of) begin
      of_sticky <= 1'b1;
    end else if (clr_of) begin
      of_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_pipe.sv
// Bench for alu_seq_pipe: table of ALU vectors plus directed sequences for
// key debounce/stepping, backpressure, opcode snapshot, sticky flag and reset.
module tb_alu_seq_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_next;
  logic       key_prev;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dina;
  logic [7:0] dinb;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] doutr;
  logic       doutz;
  logic       flag_c;
  logic       flag_of;
  logic       of_sticky;
  logic       clr_of;
  logic [3:0] op_sel;
  logic [3:0] op_out;

  int errors = 0;
  int checks = 0;

  alu_seq_pipe #(
    .DATA_WIDTH   (8),
    .NUM_OPS      (10),
    .DEBOUNCE_CYC (20'd4),
    .KEY_ACTIVE   (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_next  (key_next),
    .key_prev  (key_prev),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dina      (dina),
    .dinb      (dinb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .doutr     (doutr),
    .doutz     (doutz),
    .flag_c    (flag_c),
    .flag_of   (flag_of),
    .of_sticky (of_sticky),
    .clr_of    (clr_of),
    .op_sel    (op_sel),
    .op_out    (op_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       v;
    string      nm;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold keys long enough for sync + debounce, then release likewise
  task automatic press(input logic nxt, input logic prv);
    key_next = nxt;
    key_prev = prv;
    repeat (8) step();
    key_next = 1'b0;
    key_prev = 1'b0;
    repeat (8) step();
  endtask

  task automatic goto_op(input logic [3:0] target);
    for (int i = 0; i < 16; i++) begin
      if (op_sel == target) break;
      press(1'b1, 1'b0);
    end
    chk("goto_op", 32'(op_sel), 32'(target));
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    dina     = a;
    dinb     = b;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) timeout("send_in_ready");
    step();
    in_valid = 1'b0;
  endtask

  task automatic collect(input string nm, input logic [7:0] r, input logic z,
                         input logic c, input logic v, input logic [3:0] op,
                         input logic clr);
    bit ok;
    ok        = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        chk({nm, "_r"},  32'(doutr),   32'(r));
        chk({nm, "_z"},  32'(doutz),   32'(z));
        chk({nm, "_c"},  32'(flag_c),  32'(c));
        chk({nm, "_of"}, 32'(flag_of), 32'(v));
        chk({nm, "_op"}, 32'(op_out),  32'(op));
        clr_of = clr;
        step();
        clr_of = 1'b0;
        break;
      end
      step();
    end
    if (!ok) timeout({nm, "_out_valid"});
  endtask

  initial begin
    logic [7:0] exp_bp[4];
    logic [7:0] hold;
    int         k;
    int         got;
    bit         fire_in;
    bit         fire_out;

    vecs[0]  = '{4'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, "add_ovf"};
    vecs[1]  = '{4'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, "add_carry"};
    vecs[2]  = '{4'd0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, "add_plain"};
    vecs[3]  = '{4'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, "sub_ovf"};
    vecs[4]  = '{4'd1, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b1, 1'b0, "sub_borrow"};
    vecs[5]  = '{4'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, "sub_zero"};
    vecs[6]  = '{4'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, "and"};
    vecs[7]  = '{4'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, "or"};
    vecs[8]  = '{4'd4, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, "xor"};
    vecs[9]  = '{4'd5, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0, "nor"};
    vecs[10] = '{4'd6, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, "slt_neg"};
    vecs[11] = '{4'd6, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, "slt_pos"};
    vecs[12] = '{4'd7, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, "sll"};
    vecs[13] = '{4'd8, 8'h90, 8'hFA, 8'h24, 1'b0, 1'b0, 1'b0, "srl"};
    vecs[14] = '{4'd9, 8'h90, 8'h0A, 8'hE4, 1'b0, 1'b0, 1'b0, "sra_neg"};
    vecs[15] = '{4'd9, 8'h70, 8'h03, 8'h0E, 1'b0, 1'b0, 1'b0, "sra_pos"};

    rst_n     = 1'b1;
    key_next  = 1'b0;
    key_prev  = 1'b0;
    in_valid  = 1'b0;
    dina      = '0;
    dinb      = '0;
    out_ready = 1'b1;
    clr_of    = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();

    // Reset state
    chk("rst_op_sel",    32'(op_sel),    32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_doutr",     32'(doutr),     32'd0);
    chk("rst_doutz",     32'(doutz),     32'd0);
    chk("rst_flag_c",    32'(flag_c),    32'd0);
    chk("rst_flag_of",   32'(flag_of),   32'd0);
    chk("rst_of_sticky", 32'(of_sticky), 32'd0);
    chk("rst_op_out",    32'(op_out),    32'd0);

    // Bounce 1-0-1 then hold: exactly one step
    key_next = 1'b1; step();
    key_next = 1'b0; step();
    key_next = 1'b1;
    repeat (12) step();
    chk("bounce_hold", 32'(op_sel), 32'd1);
    key_next = 1'b0;
    repeat (10) step();
    chk("bounce_release", 32'(op_sel), 32'd1);

    press(1'b0, 1'b1);
    chk("prev_to_0", 32'(op_sel), 32'd0);
    for (int i = 0; i < 10; i++) begin
      press(1'b0, 1'b1);
      chk("prev_seq", 32'(op_sel), 32'(9 - i));
    end

    press(1'b1, 1'b1);
    chk("both_keys", 32'(op_sel), 32'd0);

    // ALU vector table
    for (int i = 0; i < 16; i++) begin
      goto_op(vecs[i].op);
      send(vecs[i].a, vecs[i].b);
      collect(vecs[i].nm, vecs[i].r, vecs[i].z, vecs[i].c, vecs[i].v, vecs[i].op, 1'b0);
    end

    press(1'b1, 1'b0);
    chk("wrap_next", 32'(op_sel), 32'd0);

    // Opcode snapshot: first result parked in S2 while op_sel steps
    out_ready = 1'b0;
    send(8'd5, 8'd3);
    key_next = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (op_sel == 4'd1) break;
      step();
    end
    chk("snap_op_step", 32'(op_sel), 32'd1);
    chk("snap_parked",  32'(out_valid), 32'd1);
    send(8'd5, 8'd3);
    key_next = 1'b0;
    collect("snap_add", 8'h08, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    collect("snap_sub", 8'h02, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    repeat (8) step();

    // Backpressure: four ADDs, out_ready low while the first result waits
    goto_op(4'd0);
    for (int i = 0; i < 4; i++) exp_bp[i] = 8'(10 * i + 11);
    k    = 0;
    got  = 0;
    hold = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (k < 4);
      dina      = 8'(10 * k + 10);
      dinb      = 8'd1;
      #1;
      if (cyc == 2) begin
        chk("bp_accepted", 32'(k), 32'd2);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        hold = doutr;
      end
      if (cyc == 3 || cyc == 4) begin
        chk("bp_hold_r", 32'(doutr), 32'(hold));
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        chk("bp_order", 32'(doutr), 32'(exp_bp[got]));
        got++;
      end
      @(posedge clk);
      #1;
      if (fire_in) k++;
    end
    in_valid = 1'b0;
    chk("bp_sent", 32'(k), 32'd4);
    chk("bp_got",  32'(got), 32'd4);
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Sticky overflow
    out_ready = 1'b1;
    clr_of = 1'b1; step(); clr_of = 1'b0;
    chk("stk_clr_init", 32'(of_sticky), 32'd0);
    send(8'h7F, 8'h01);
    collect("stk_ovf", 8'h80, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    chk("stk_set", 32'(of_sticky), 32'd1);
    send(8'h01, 8'h01);
    collect("stk_plain", 8'h02, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("stk_hold", 32'(of_sticky), 32'd1);
    send(8'h7F, 8'h01);
    collect("stk_clr_same", 8'h80, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
    chk("stk_set_wins", 32'(of_sticky), 32'd1);
    clr_of = 1'b1; step(); clr_of = 1'b0;
    chk("stk_clr", 32'(of_sticky), 32'd0);

    // Reset mid-operation with both stages full and op_sel=3
    send(8'h7F, 8'h01);
    collect("pre_rst_ovf", 8'h80, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    goto_op(4'd3);
    out_ready = 1'b0;
    send(8'h01, 8'h02);
    send(8'h03, 8'h04);
    chk("pre_rst_full_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_full_ready", 32'(in_ready),  32'd0);
    chk("pre_rst_sticky",     32'(of_sticky), 32'd1);
    rst_n = 1'b1;
    step();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_op_sel",    32'(op_sel),    32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_sticky",    32'(of_sticky), 32'd0);
    chk("mid_rst_doutr",     32'(doutr),     32'd0);
    rst_n = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_pipe.md
Name: alu_seq_pipe

Overview:
- Parametrised successor to the key-stepped ALU top.
- A debounced key pair steps a registered opcode up or down through an operation table, with wrap-around in both directions.
- Operands enter a two-stage valid/ready pipeline. Each transaction carries a snapshot of its opcode; the registered result is presented with zero, carry and overflow flags, and a sticky overflow status is maintained.
- Sits between board-level key/switch inputs and the result display/capture logic.

Parameters:
- DATA_WIDTH, 8: operand/result width, >= 4.
- NUM_OPS, 10: number of selectable opcodes (1..16). The opcode steps through 0..NUM_OPS-1.
- DEBOUNCE_CYC, 20'd500000: clock cycles a key level must stay stable before it is accepted. Minimum 2.
- KEY_ACTIVE, 1'b1: key level meaning "pressed".

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-high. Asserted when 1 despite the name.
- key_next  in  1  raw key, step opcode +1.
- key_prev  in  1  raw key, step opcode -1.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  pipeline can accept operands.
- dina  in  DATA_WIDTH  operand A.
- dinb  in  DATA_WIDTH  operand B. The low clog2(DATA_WIDTH) bits are the shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- doutr  out  DATA_WIDTH  result.
- doutz  out  1  result == 0.
- flag_c  out  1  carry/borrow out (ADD/SUB only, else 0).
- flag_of  out  1  signed overflow (ADD/SUB only, else 0).
- of_sticky  out  1  set by any accepted result with flag_of=1.
- clr_of  in  1  synchronous clear of of_sticky.
- op_sel  out  4  current opcode register.
- op_out  out  4  opcode that produced doutr.

Behaviour:
- Reset (async, rst_n=1): op_sel=0, both pipeline stages empty, out_valid=0, doutr=0, doutz=0, flag_c=0, flag_of=0, of_sticky=0, op_out=0, in_ready=1. Debouncers return to the "released" state with counters cleared.
- Debounce, per key:
  - 2-flop synchroniser, then a counter.
  - Accepted level updates after the synchronised level has differed from it for DEBOUNCE_CYC consecutive cycles; any bounce restarts the counter.
  - A one-cycle press pulse is issued on the accepted released->pressed transition only. Holding a key gives exactly one step.
- Opcode stepping:
  - next pulse: op_sel = (op_sel == NUM_OPS-1) ? 0 : op_sel+1.
  - prev pulse: op_sel = (op_sel == 0) ? NUM_OPS-1 : op_sel-1.
  - Both pulses in the same cycle: no change.
  - Updates take effect in the cycle after the pulse.
- Opcodes (shared package):
  - 0 ADD, 1 SUB (A-B).
  - 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed, result 1/0 zero-extended).
  - 7 SLL, 8 SRL, 9 SRA.
  - Opcodes >= NUM_OPS are unreachable. If they are ever decoded, the result is 0 with flags 0.
- Arithmetic:
  - ADD/SUB are computed at DATA_WIDTH+1 bits. flag_c = bit DATA_WIDTH, which is the borrow for SUB (1 when A<B unsigned).
  - flag_of: ADD sets it when the operand signs are equal and the result sign differs. SUB sets it when the operand signs differ and the result sign differs from A.
  - Shift amount = dinb[clog2(DATA_WIDTH)-1:0]. SRA replicates the MSB.
- Pipeline:
  - S1 registers dina, dinb and op_sel on an in_valid & in_ready transfer.
  - S2 registers the computed result, flags and op_out.
  - Latency: a transfer in cycle N gives out_valid in cycle N+2 when unstalled.
  - Stage advance rules:
    - S2 loads when S2 is empty or out_ready=1.
    - S1 loads when S1 is empty or S1 advances.
    - in_ready = ~s1_valid | s2_can_load. This is combinational from out_ready; there is no skid buffer.
  - Throughput: one result per cycle while out_ready=1.
  - While out_valid=1 and out_ready=0, doutr, the flags and op_out hold stable.
- Opcode changes while transactions are in flight do not affect them; each uses its snapshot.
- of_sticky: set on an out_valid & out_ready transfer whose flag_of=1. clr_of clears it. If set and clear happen in the same cycle, set wins.
- doutz reflects doutr only. It is meaningful only when out_valid=1.

Decomposition:
- Shared package alu_seq_pkg:
  - opcode width constant (4);
  - localparams OP_ADD..OP_SRA;
  - function computing {result, c, of} for a given opcode, operands and width.
- Sub-module key_debounce, instantiated twice. Parameters DEBOUNCE_CYC and KEY_ACTIVE. Ports clk, rst_n (active-high async), key_raw, key_level, key_press.

Test Plan:
- Reset mid-operation: assert rst_n while both stages are full and op_sel=3 -> next cycle out_valid=0, op_sel=0, in_ready=1, of_sticky=0.
- Key stepping (DEBOUNCE_CYC=4): bounce key_next 1-0-1 within 3 cycles, then hold -> exactly one step, 0->1. Ten prev presses from 0 -> op_sel sequence 9,8,...,0. next and prev pressed together -> op_sel unchanged.
- Arithmetic, W=8:
  - ADD 0x7F+0x01 -> 0x80, of=1, c=0.
  - ADD 0xFF+0x01 -> 0x00, doutz=1, c=1, of=0.
  - SUB 0x80-0x01 -> 0x7F, of=1, c=0.
  - SUB 0x01-0x02 -> 0xFF, c=1.
  - SLT 0xFF,0x01 -> 0x01.
  - SRA 0x90 by 2 -> 0xE4; SRL 0x90 by 2 -> 0x24.
- Backpressure: stream 4 ADDs with out_ready low for 3 cycles -> in_ready drops after 2 accepted, outputs held stable, all 4 delivered in order, no loss or duplication.
- Opcode snapshot: send A=5, B=3 with op_sel=ADD, then press next the following cycle and send again -> results 8 (op_out=0), then 2 (op_out=1).
- Sticky flag: produce an ADD overflow, then a non-overflow result -> of_sticky stays 1. Pulse clr_of in the same cycle as another overflow transfer -> of_sticky=1. clr_of alone -> 0.
